// File: rtl/dram_bank_model.sv
// dram_bank_model: device-side DRAM bank responder. Tracks per-bank open-row
// state and activate/precharge timing, a global refresh overlay, backing
// storage, and a CAS-latency read pipeline. Illegal commands are dropped and
// reported with a one-cycle cmd_err pulse.
module dram_bank_model #(
  parameter int NUMBER_OF_BANKS = 8,
  parameter int NUMBER_OF_ROWS  = 128,
  parameter int NUMBER_OF_COLS  = 8,
  parameter int DATA_WIDTH      = 16,
  parameter int T_RCD           = 2,
  parameter int T_RP            = 2,
  parameter int T_RFC           = 4,
  parameter int CL              = 2
) (
  input  logic                               clk,
  input  logic                               rst_b,
  input  logic [1:0]                         cmd,
  input  logic                               wr_en,
  input  logic [$clog2(NUMBER_OF_BANKS)-1:0] bank_id,
  input  logic [$clog2(NUMBER_OF_ROWS)-1:0]  row_id,
  input  logic [$clog2(NUMBER_OF_COLS)-1:0]  col_id,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  input  logic                               refresh_flag,
  output logic [DATA_WIDTH-1:0]              rd_data,
  output logic                               rd_valid,
  output logic [NUMBER_OF_BANKS-1:0]         bank_busy,
  output logic [NUMBER_OF_BANKS-1:0]         bank_open,
  output logic                               cmd_err,
  output logic                               refresh_done
);

  localparam int BANK_W  = $clog2(NUMBER_OF_BANKS);
  localparam int ROW_W   = $clog2(NUMBER_OF_ROWS);
  localparam int COL_W   = $clog2(NUMBER_OF_COLS);
  localparam int ADDR_W  = BANK_W + ROW_W + COL_W;
  localparam int DEPTH   = NUMBER_OF_BANKS * NUMBER_OF_ROWS * NUMBER_OF_COLS;
  localparam int CNT_MAX = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RFC_W   = $clog2(T_RFC + 1);

  localparam logic [1:0] CMD_NOP = 2'b00;
  localparam logic [1:0] CMD_ACT = 2'b01;
  localparam logic [1:0] CMD_PRE = 2'b10;
  localparam logic [1:0] CMD_RW  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_ACTIVATING  = 2'd1,
    ST_ACTIVE      = 2'd2,
    ST_PRECHARGING = 2'd3
  } bank_state_t;

  bank_state_t                state      [NUMBER_OF_BANKS];
  bank_state_t                state_nxt  [NUMBER_OF_BANKS];
  logic [ROW_W-1:0]           open_row     [NUMBER_OF_BANKS];
  logic [ROW_W-1:0]           open_row_nxt [NUMBER_OF_BANKS];
  logic [CNT_W-1:0]           cnt        [NUMBER_OF_BANKS];
  logic [CNT_W-1:0]           cnt_nxt    [NUMBER_OF_BANKS];
  logic                       refreshing, refreshing_nxt;
  logic [RFC_W-1:0]           rfc_cnt, rfc_cnt_nxt;
  logic [NUMBER_OF_BANKS-1:0] busy_nxt, open_nxt;
  logic                       err_nxt, done_nxt, rd_hit, wr_hit, all_idle;
  logic [ADDR_W-1:0]          mem_addr;
  logic [DATA_WIDTH-1:0]      mem [DEPTH];
  logic [CL-1:0]              vld;
  logic [DATA_WIDTH-1:0]      dat [CL];

  // Next-state: bank timing countdown, command legality/effects, refresh overlay
  always_comb begin
    state_nxt      = state;
    open_row_nxt   = open_row;
    cnt_nxt        = cnt;
    refreshing_nxt = refreshing;
    rfc_cnt_nxt    = rfc_cnt;
    err_nxt        = 1'b0;
    rd_hit         = 1'b0;
    wr_hit         = 1'b0;
    all_idle       = 1'b1;
    busy_nxt       = {NUMBER_OF_BANKS{1'b0}};
    open_nxt       = {NUMBER_OF_BANKS{1'b0}};
    mem_addr       = {bank_id, open_row[bank_id], col_id};

    for (int b = 0; b < NUMBER_OF_BANKS; b++) begin
      all_idle = all_idle & (state[b] == ST_IDLE);
      case (state[b])
        ST_ACTIVATING: begin
          if (cnt[b] <= CNT_W'(1)) begin
            state_nxt[b] = ST_ACTIVE;
            cnt_nxt[b]   = CNT_W'(0);
          end else begin
            cnt_nxt[b]   = cnt[b] - CNT_W'(1);
          end
        end
        ST_PRECHARGING: begin
          if (cnt[b] <= CNT_W'(1)) begin
            state_nxt[b] = ST_IDLE;
            cnt_nxt[b]   = CNT_W'(0);
          end else begin
            cnt_nxt[b]   = cnt[b] - CNT_W'(1);
          end
        end
        default: state_nxt[b] = state[b];
      endcase
    end

    // Commands only ever take effect on IDLE/ACTIVE banks, so they never
    // collide with the countdown updates above.
    case (cmd)
      CMD_ACT: begin
        if (!refreshing && (state[bank_id] == ST_IDLE)) begin
          open_row_nxt[bank_id] = row_id;
          if (T_RCD == 1) begin
            state_nxt[bank_id] = ST_ACTIVE;
            cnt_nxt[bank_id]   = CNT_W'(0);
          end else begin
            state_nxt[bank_id] = ST_ACTIVATING;
            cnt_nxt[bank_id]   = CNT_W'(T_RCD - 1);
          end
        end else begin
          err_nxt = 1'b1;
        end
      end
      CMD_PRE: begin
        if (refreshing) begin
          err_nxt = 1'b1;
        end else begin
          case (state[bank_id])
            ST_ACTIVE: begin
              if (T_RP == 1) begin
                state_nxt[bank_id] = ST_IDLE;
                cnt_nxt[bank_id]   = CNT_W'(0);
              end else begin
                state_nxt[bank_id] = ST_PRECHARGING;
                cnt_nxt[bank_id]   = CNT_W'(T_RP - 1);
              end
            end
            ST_IDLE: err_nxt = 1'b0;
            default: err_nxt = 1'b1;
          endcase
        end
      end
      CMD_RW: begin
        if (!refreshing && (state[bank_id] == ST_ACTIVE)) begin
          rd_hit = ~wr_en;
          wr_hit = wr_en;
        end else begin
          err_nxt = 1'b1;
        end
      end
      default: err_nxt = 1'b0;
    endcase

    // A refresh only starts from a quiet, all-idle device; any command wins.
    if (refreshing) begin
      if (rfc_cnt == RFC_W'(0)) begin
        refreshing_nxt = 1'b0;
      end else begin
        rfc_cnt_nxt = rfc_cnt - RFC_W'(1);
      end
    end else if (refresh_flag && (cmd == CMD_NOP) && all_idle) begin
      refreshing_nxt = 1'b1;
      rfc_cnt_nxt    = RFC_W'(T_RFC - 1);
    end else begin
      refreshing_nxt = 1'b0;
    end

    done_nxt = refreshing_nxt && (rfc_cnt_nxt == RFC_W'(0));
    for (int b = 0; b < NUMBER_OF_BANKS; b++) begin
      busy_nxt[b] = refreshing_nxt || (state_nxt[b] == ST_ACTIVATING) ||
                    (state_nxt[b] == ST_PRECHARGING);
      open_nxt[b] = (state_nxt[b] == ST_ACTIVE);
    end
  end

  // Bank/refresh state registers and registered status outputs
  always_ff @(posedge clk) begin
    if (rst_b) begin
      for (int b = 0; b < NUMBER_OF_BANKS; b++) begin
        state[b]    <= ST_IDLE;
        open_row[b] <= {ROW_W{1'b0}};
        cnt[b]      <= {CNT_W{1'b0}};
      end
      refreshing   <= 1'b0;
      rfc_cnt      <= {RFC_W{1'b0}};
      bank_busy    <= {NUMBER_OF_BANKS{1'b0}};
      bank_open    <= {NUMBER_OF_BANKS{1'b0}};
      cmd_err      <= 1'b0;
      refresh_done <= 1'b0;
    end else begin
      state        <= state_nxt;
      open_row     <= open_row_nxt;
      cnt          <= cnt_nxt;
      refreshing   <= refreshing_nxt;
      rfc_cnt      <= rfc_cnt_nxt;
      bank_busy    <= busy_nxt;
      bank_open    <= open_nxt;
      cmd_err      <= err_nxt;
      refresh_done <= done_nxt;
    end
  end

  // Backing storage write; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (wr_hit && !rst_b) begin
      mem[mem_addr] <= wr_data;
    end
  end

  // CL-deep read pipeline; data stages only advance with a valid word so the
  // output holds its last value between reads
  always_ff @(posedge clk) begin
    if (rst_b) begin
      vld <= {CL{1'b0}};
      for (int k = 0; k < CL; k++) begin
        dat[k] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      vld[0] <= rd_hit;
      if (rd_hit) begin
        dat[0] <= mem[mem_addr];
      end
      for (int k = 1; k < CL; k++) begin
        vld[k] <= vld[k-1];
        if (vld[k-1]) begin
          dat[k] <= dat[k-1];
        end
      end
    end
  end

  assign rd_valid = vld[CL-1];
  assign rd_data  = dat[CL-1];

endmodule

// File: tb/tb_dram_bank_model.sv
// tb_dram_bank_model: directed scenarios against the default-parameter
// dram_bank_model (8 banks, T_RCD=2, T_RP=2, T_RFC=4, CL=2).
module tb_dram_bank_model;

  logic        clk;
  logic        rst_b;
  logic [1:0]  cmd;
  logic        wr_en;
  logic [2:0]  bank_id;
  logic [6:0]  row_id;
  logic [2:0]  col_id;
  logic [15:0] wr_data;
  logic        refresh_flag;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [7:0]  bank_busy;
  logic [7:0]  bank_open;
  logic        cmd_err;
  logic        refresh_done;

  int n_vec;
  int n_err;

  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] ACT = 2'b01;
  localparam logic [1:0] PRE = 2'b10;
  localparam logic [1:0] RW  = 2'b11;

  logic [15:0] dvals [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};

  dram_bank_model dut (
    .clk(clk), .rst_b(rst_b), .cmd(cmd), .wr_en(wr_en), .bank_id(bank_id),
    .row_id(row_id), .col_id(col_id), .wr_data(wr_data),
    .refresh_flag(refresh_flag), .rd_data(rd_data), .rd_valid(rd_valid),
    .bank_busy(bank_busy), .bank_open(bank_open), .cmd_err(cmd_err),
    .refresh_done(refresh_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance into the next cycle; outputs are stable from here on
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] c, input logic w, input logic [2:0] b,
                       input logic [6:0] r, input logic [2:0] co, input logic [15:0] d);
    cmd = c; wr_en = w; bank_id = b; row_id = r; col_id = co; wr_data = d;
  endtask

  task automatic idle();
    drive(NOP, 1'b0, 3'd0, 7'd0, 3'd0, 16'h0000);
  endtask

  task automatic test_reset();
    rst_b = 1'b1; refresh_flag = 1'b0; idle();
    tick(); tick();
    rst_b = 1'b0;
    n_vec++;
    if ({rd_data, rd_valid, bank_busy, bank_open, cmd_err, refresh_done} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_outputs: data=%h v=%b busy=%h open=%h err=%b done=%b, want all 0",
               rd_data, rd_valid, bank_busy, bank_open, cmd_err, refresh_done);
    end
  endtask

  task automatic test_act_write_read();
    drive(ACT, 1'b0, 3'd3, 7'd5, 3'd0, 16'h0000); tick();
    n_vec++;
    if (bank_busy !== 8'h08 || bank_open !== 8'h00) begin
      n_err++; $display("FAIL act_busy: busy=%h open=%h, want 08/00", bank_busy, bank_open);
    end
    idle(); tick();
    n_vec++;
    if (bank_busy !== 8'h00 || bank_open !== 8'h08) begin
      n_err++; $display("FAIL act_open: busy=%h open=%h, want 00/08", bank_busy, bank_open);
    end
    drive(RW, 1'b1, 3'd3, 7'd0, 3'd2, 16'hBEEF); tick();
    n_vec++;
    if (cmd_err !== 1'b0) begin
      n_err++; $display("FAIL write_legal: cmd_err=%b, want 0", cmd_err);
    end
    drive(RW, 1'b0, 3'd3, 7'd0, 3'd2, 16'h0000); tick();
    n_vec++;
    if (rd_valid !== 1'b0) begin
      n_err++; $display("FAIL read_early: rd_valid=%b, want 0", rd_valid);
    end
    idle(); tick();
    n_vec++;
    if (rd_valid !== 1'b1 || rd_data !== 16'hBEEF) begin
      n_err++; $display("FAIL read_beef: v=%b data=%h, want 1/beef", rd_valid, rd_data);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    for (int i = 0; i < 4; i++) begin
      drive(RW, 1'b1, 3'd3, 7'd0, 3'(i), dvals[i]); tick();
    end
    idle(); tick();
    for (int t = 0; t < 7; t++) begin
      exp_v = (t >= 2) && (t <= 5);
      n_vec++;
      if (rd_valid !== exp_v) begin
        n_err++; $display("FAIL b2b_valid[%0d]: rd_valid=%b, want %b", t, rd_valid, exp_v);
      end
      if (exp_v) begin
        n_vec++;
        if (rd_data !== dvals[t-2]) begin
          n_err++; $display("FAIL b2b_data[%0d]: rd_data=%h, want %h", t, rd_data, dvals[t-2]);
        end
      end
      if (t < 4) drive(RW, 1'b0, 3'd3, 7'd0, 3'(t), 16'h0000);
      else idle();
      tick();
    end
  endtask

  task automatic test_illegal();
    // RW to an IDLE bank
    drive(RW, 1'b0, 3'd1, 7'd0, 3'd0, 16'h0000); tick();
    n_vec++;
    if (cmd_err !== 1'b1 || bank_open !== 8'h08 || bank_busy !== 8'h00) begin
      n_err++; $display("FAIL rw_idle_err: err=%b open=%h busy=%h, want 1/08/00", cmd_err, bank_open, bank_busy);
    end
    idle(); tick();
    n_vec++;
    if (cmd_err !== 1'b0 || rd_valid !== 1'b0) begin
      n_err++; $display("FAIL rw_idle_pulse: err=%b v=%b, want 0/0", cmd_err, rd_valid);
    end
    tick();
    n_vec++;
    if (rd_valid !== 1'b0) begin
      n_err++; $display("FAIL rw_idle_noread: rd_valid=%b, want 0", rd_valid);
    end
    // ACT to an ACTIVE bank must not change its open row
    drive(ACT, 1'b0, 3'd3, 7'd9, 3'd0, 16'h0000); tick();
    n_vec++;
    if (cmd_err !== 1'b1 || bank_open !== 8'h08 || bank_busy !== 8'h00) begin
      n_err++; $display("FAIL act_active_err: err=%b open=%h busy=%h, want 1/08/00", cmd_err, bank_open, bank_busy);
    end
    drive(RW, 1'b0, 3'd3, 7'd0, 3'd0, 16'h0000); tick();
    n_vec++;
    if (cmd_err !== 1'b0) begin
      n_err++; $display("FAIL act_active_pulse: cmd_err=%b, want 0", cmd_err);
    end
    idle(); tick();
    n_vec++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h1234) begin
      n_err++; $display("FAIL act_active_row: v=%b data=%h, want 1/1234", rd_valid, rd_data);
    end
    // ACT while PRECHARGING
    drive(PRE, 1'b0, 3'd3, 7'd0, 3'd0, 16'h0000); tick();
    n_vec++;
    if (bank_busy !== 8'h08 || bank_open !== 8'h00 || cmd_err !== 1'b0) begin
      n_err++; $display("FAIL pre_busy: busy=%h open=%h err=%b, want 08/00/0", bank_busy, bank_open, cmd_err);
    end
    drive(ACT, 1'b0, 3'd3, 7'd9, 3'd0, 16'h0000); tick();
    n_vec++;
    if (cmd_err !== 1'b1 || bank_busy !== 8'h00 || bank_open !== 8'h00) begin
      n_err++; $display("FAIL act_prech_err: err=%b busy=%h open=%h, want 1/00/00", cmd_err, bank_busy, bank_open);
    end
    idle(); tick();
    n_vec++;
    if (cmd_err !== 1'b0 || bank_busy !== 8'h00 || bank_open !== 8'h00) begin
      n_err++; $display("FAIL act_prech_drop: err=%b busy=%h open=%h, want 0/00/00", cmd_err, bank_busy, bank_open);
    end
  endtask

  task automatic test_refresh();
    refresh_flag = 1'b1; idle(); tick();            // cycle 11
    n_vec++;
    if (bank_busy !== 8'hFF || refresh_done !== 1'b0) begin
      n_err++; $display("FAIL ref_c11: busy=%h done=%b, want ff/0", bank_busy, refresh_done);
    end
    tick();                                          // cycle 12
    n_vec++;
    if (bank_busy !== 8'hFF) begin
      n_err++; $display("FAIL ref_c12: busy=%h, want ff", bank_busy);
    end
    drive(ACT, 1'b0, 3'd2, 7'd1, 3'd0, 16'h0000); tick();  // cycle 13
    n_vec++;
    if (cmd_err !== 1'b1 || bank_busy !== 8'hFF || refresh_done !== 1'b0) begin
      n_err++; $display("FAIL ref_c13: err=%b busy=%h done=%b, want 1/ff/0", cmd_err, bank_busy, refresh_done);
    end
    idle(); tick();                                  // cycle 14
    n_vec++;
    if (bank_busy !== 8'hFF || refresh_done !== 1'b1 || cmd_err !== 1'b0) begin
      n_err++; $display("FAIL ref_c14: busy=%h done=%b err=%b, want ff/1/0", bank_busy, refresh_done, cmd_err);
    end
    tick();                                          // cycle 15
    n_vec++;
    if (bank_busy !== 8'h00 || refresh_done !== 1'b0 || bank_open !== 8'h00) begin
      n_err++; $display("FAIL ref_c15: busy=%h done=%b open=%h, want 00/0/00", bank_busy, refresh_done, bank_open);
    end
    refresh_flag = 1'b0; tick();
    n_vec++;
    if (bank_busy !== 8'h00) begin
      n_err++; $display("FAIL ref_c16: busy=%h, want 00", bank_busy);
    end
  endtask

  task automatic test_refresh_deferred();
    drive(ACT, 1'b0, 3'd0, 7'd7, 3'd0, 16'h0000); tick(); idle(); tick();
    drive(RW, 1'b1, 3'd0, 7'd0, 3'd1, 16'h5A5A); tick();
    refresh_flag = 1'b1; idle(); tick(); tick();
    n_vec++;
    if (bank_busy !== 8'h00 || bank_open !== 8'h01 || refresh_done !== 1'b0) begin
      n_err++; $display("FAIL defer_active: busy=%h open=%h done=%b, want 00/01/0", bank_busy, bank_open, refresh_done);
    end
    drive(PRE, 1'b0, 3'd0, 7'd0, 3'd0, 16'h0000); tick();  // P+1
    n_vec++;
    if (bank_busy !== 8'h01 || bank_open !== 8'h00) begin
      n_err++; $display("FAIL defer_pre: busy=%h open=%h, want 01/00", bank_busy, bank_open);
    end
    idle(); tick();                                         // P+2
    n_vec++;
    if (bank_busy !== 8'h00) begin
      n_err++; $display("FAIL defer_idle: busy=%h, want 00", bank_busy);
    end
    tick();                                                 // P+3
    n_vec++;
    if (bank_busy !== 8'hFF) begin
      n_err++; $display("FAIL defer_start: busy=%h, want ff", bank_busy);
    end
    tick(); tick(); tick();                                 // P+6
    n_vec++;
    if (refresh_done !== 1'b1) begin
      n_err++; $display("FAIL defer_done: refresh_done=%b, want 1", refresh_done);
    end
    refresh_flag = 1'b0; tick();
    drive(ACT, 1'b0, 3'd0, 7'd7, 3'd0, 16'h0000); tick(); idle(); tick();
    drive(RW, 1'b0, 3'd0, 7'd0, 3'd1, 16'h0000); tick(); idle(); tick();
    n_vec++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h5A5A) begin
      n_err++; $display("FAIL defer_data: v=%b data=%h, want 1/5a5a", rd_valid, rd_data);
    end
  endtask

  task automatic test_reset_mid();
    drive(PRE, 1'b0, 3'd0, 7'd0, 3'd0, 16'h0000); tick(); idle(); tick();
    refresh_flag = 1'b1; tick(); tick();
    rst_b = 1'b1; refresh_flag = 1'b0; tick();
    rst_b = 1'b0;
    n_vec++;
    if ({rd_data, rd_valid, bank_busy, bank_open, cmd_err, refresh_done} !== 35'd0) begin
      n_err++; $display("FAIL rst_refresh: data=%h v=%b busy=%h open=%h err=%b done=%b, want all 0",
                        rd_data, rd_valid, bank_busy, bank_open, cmd_err, refresh_done);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if (refresh_done !== 1'b0 || bank_busy !== 8'h00) begin
        n_err++; $display("FAIL rst_refresh_quiet[%0d]: done=%b busy=%h, want 0/00", i, refresh_done, bank_busy);
      end
    end
    drive(ACT, 1'b0, 3'd0, 7'd7, 3'd0, 16'h0000); tick(); idle(); tick();
    drive(RW, 1'b0, 3'd0, 7'd0, 3'd1, 16'h0000); tick();
    idle(); rst_b = 1'b1; tick();
    rst_b = 1'b0;
    n_vec++;
    if ({rd_data, rd_valid, bank_busy, bank_open, cmd_err, refresh_done} !== 35'd0) begin
      n_err++; $display("FAIL rst_read: data=%h v=%b busy=%h open=%h err=%b done=%b, want all 0",
                        rd_data, rd_valid, bank_busy, bank_open, cmd_err, refresh_done);
    end
    tick();
    n_vec++;
    if (rd_valid !== 1'b0 || bank_open !== 8'h00) begin
      n_err++; $display("FAIL rst_read_quiet: v=%b open=%h, want 0/00", rd_valid, bank_open);
    end
    drive(ACT, 1'b0, 3'd0, 7'd7, 3'd0, 16'h0000); tick(); idle(); tick();
    drive(RW, 1'b0, 3'd0, 7'd0, 3'd1, 16'h0000); tick(); idle(); tick();
    n_vec++;
    if (rd_valid !== 1'b1 || rd_data !== 16'h5A5A) begin
      n_err++; $display("FAIL rst_storage: v=%b data=%h, want 1/5a5a", rd_valid, rd_data);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_b = 1'b1;
    refresh_flag = 1'b0;
    idle();
    test_reset();
    test_act_write_read();
    test_back_to_back();
    test_illegal();
    test_refresh();
    test_refresh_deferred();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Run-length guard
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, want completion");
    $fatal(1);
  end

endmodule

// File: doc/dram_bank_model.md
# dram_bank_model

Command-responder end of the DRAM controller interface. Accepts the 2-bit command stream plus bank/row/column addressing issued by the controller FSM and holds per-bank open-row state, timing counters and backing storage. Returns CAS-latency-delayed read data and flags illegal commands. Used as the device side in controller simulation and as the bank-state reference for verification.

## Interface

- NUMBER_OF_BANKS, 8, bank count (power of two, ≥2)
- NUMBER_OF_ROWS, 128, rows per bank (power of two)
- NUMBER_OF_COLS, 8, column words per row (power of two)
- DATA_WIDTH, 16, data word width
- T_RCD, 2, ACT→RW spacing in cycles (≥1)
- T_RP, 2, PRE→IDLE spacing in cycles (≥1)
- T_RFC, 4, refresh duration in cycles (≥1)
- CL, 2, read latency in cycles (≥1)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_b  in  1  synchronous, active-high reset (rst_b=1 resets on the next edge)
- cmd  in  2  00 NOP, 01 ACT, 10 PRE, 11 RW
- wr_en  in  1  qualifies RW: 1 write, 0 read
- bank_id  in  $clog2(NUMBER_OF_BANKS)  target bank
- row_id  in  $clog2(NUMBER_OF_ROWS)  row; used by ACT only
- col_id  in  $clog2(NUMBER_OF_COLS)  column; used by RW only
- wr_data  in  DATA_WIDTH  write data, same cycle as RW write
- refresh_flag  in  1  refresh request, level, held until refresh_done
- rd_data  out  DATA_WIDTH  read data
- rd_valid  out  1  rd_data valid strobe
- bank_busy  out  NUMBER_OF_BANKS  bank in ACTIVATING/PRECHARGING/REFRESHING
- bank_open  out  NUMBER_OF_BANKS  bank in ACTIVE
- cmd_err  out  1  one-cycle pulse: previous cycle's command was illegal and dropped
- refresh_done  out  1  one-cycle pulse: refresh completed

## Operation

- Per-bank FSM: IDLE, ACTIVATING, ACTIVE, PRECHARGING; global REFRESHING overlay. Per-bank open_row register and down-counter.
- ACT to IDLE bank: latch row_id; if T_RCD=1 go to ACTIVE directly, else ACTIVATING with counter T_RCD-1; ACTIVE when counter reaches 0.
- PRE to ACTIVE bank: if T_RP=1 go to IDLE, else PRECHARGING with counter T_RP-1. PRE to IDLE bank: legal no-op.
- RW read to ACTIVE bank: fetch array[bank][open_row][col_id] into a CL-deep valid/data shift pipeline; back-to-back reads every cycle are supported.
- RW write to ACTIVE bank: array[bank][open_row][col_id] ← wr_data at the command edge; a read of the same address on the next cycle returns the new data.
- Illegal, dropped with cmd_err: ACT to non-IDLE bank; RW to non-ACTIVE bank; any non-NOP command to a busy bank; any non-NOP command while REFRESHING. State, storage and the read pipeline are unaffected.
- Refresh: starts when refresh_flag=1, cmd=NOP, all banks IDLE and not already refreshing. All bank_busy bits go high for T_RFC cycles, then refresh_done pulses and all banks stay IDLE. Storage is preserved. A refresh_flag sampled in the refresh_done cycle is ignored.
- Simultaneous refresh_flag and a non-NOP command: the command is processed and refresh is deferred.
- Reset: all banks IDLE, open_row=0, counters=0, read pipeline flushed. rd_data=0, rd_valid=0, bank_busy=0, bank_open=0, cmd_err=0, refresh_done=0. Storage is not reset. Reset mid-refresh or mid-read aborts with no refresh_done or rd_valid.

## Timing

- A command presented in cycle N takes effect at the edge ending cycle N. All outputs are registered.
- ACT in N: bank_busy high in cycles N+1..N+T_RCD-1; bank_open high from N+T_RCD; RW legal from N+T_RCD.
- PRE in N: bank_open low from N+1; bank_busy high N+1..N+T_RP-1; ACT legal from N+T_RP.
- Read in N: rd_valid=1 with data in cycle N+CL. rd_data holds its last value while rd_valid=0.
- cmd_err for a command in N: high in N+1 only.
- Refresh starting at edge ending N: bank_busy all-ones N+1..N+T_RFC; refresh_done in N+T_RFC; commands legal from N+T_RFC+1.

## Test plan

- Reset, then ACT bank 3 row 5 in cycle 0 → bank_busy[3]=1 in cycle 1, bank_open[3]=1 in cycle 2; write 0xBEEF col 2 in cycle 2, read col 2 in cycle 3 → rd_valid=1, rd_data=0xBEEF in cycle 5.
- Reads of cols 0..3 in consecutive cycles on an open bank → four consecutive rd_valid cycles, data in order, CL=2 after each command.
- RW to IDLE bank 1; ACT to ACTIVE bank 3; ACT to bank 3 during PRECHARGING → cmd_err pulse after each; no state change; no rd_valid.
- All banks IDLE, refresh_flag=1 with cmd=NOP in cycle 10 → bank_busy=0xFF in cycles 11–14, refresh_done in 14; ACT in 12 → cmd_err in 13.
- refresh_flag with bank 0 ACTIVE → no refresh; PRE bank 0 → refresh starts once bank 0 reaches IDLE and cmd=NOP; previously written data still reads back correctly after reactivating the row.
- Assert rst_b mid-refresh and with a read in flight → next cycle all outputs 0, no refresh_done, no rd_valid; the stored word is intact on a later read.
